// File: rtl/pipe_hazard_ctrl.sv
// LC-3b stall/flush sequencer: pipeline-register load enables and bubble controls (optional HAZARD_PERF_CNT_EN counters).
// Latency: controls are combinational from the registered state; the state advances once per clk.
// Backpressure: a cache miss freezes every stage; a load-use hazard holds PC/IF-ID and injects one bubble.
module pipe_hazard_ctrl #(
   parameter int STALL_CNT_W = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [3:0] id_opcode,
   input  logic       id_bit5,
   input  logic [2:0] id_sr1,
   input  logic [2:0] id_sr2,
   input  logic       ex_valid,
   input  logic [3:0] ex_opcode,
   input  logic [2:0] ex_dest,
   input  logic       mem_br_taken,
   input  logic       icache_req,
   input  logic       icache_resp,
   input  logic       dcache_req,
   input  logic       dcache_resp,
   output logic       pc_load,
   output logic       if_id_load,
   output logic       id_ex_load,
   output logic       ex_mem_load,
   output logic       mem_wb_load,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       ex_mem_flush,
   output logic [1:0] ctrl_state
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [STALL_CNT_W-1:0] miss_stall_cnt,
   output logic [STALL_CNT_W-1:0] lduse_stall_cnt,
   output logic [STALL_CNT_W-1:0] flush_cnt
`endif
);

   typedef enum logic [1:0] {
      RUN      = 2'b00,
      MEM_WAIT = 2'b01,
      REDIRECT = 2'b10,
      ILLEGAL  = 2'b11
   } state_t;

   localparam logic [3:0] OP_ADD = 4'b0001, OP_AND = 4'b0101, OP_NOT = 4'b1001;
   localparam logic [3:0] OP_LDB = 4'b0010, OP_LDR = 4'b0110, OP_LDI = 4'b1010;
   localparam logic [3:0] OP_STB = 4'b0011, OP_STR = 4'b0111, OP_STI = 4'b1011;
   localparam logic [3:0] OP_JMP = 4'b1100;

   localparam logic [4:0] LOADS_ALL   = 5'b11111;
   localparam logic [4:0] LOADS_LDUSE = 5'b00111;

   state_t     state, next_state;
   logic       flush_pending, next_flush_pending;
   logic       miss, ld_use, ex_is_load, sr1_read, sr2_read;
   logic [4:0] loads;    // {pc, if_id, id_ex, ex_mem, mem_wb}
   logic [2:0] flushes;  // {if_id, id_ex, ex_mem}

   assign miss = (icache_req & ~icache_resp) | (dcache_req & ~dcache_resp);

   always_comb begin
      sr1_read = 1'b0;
      case (id_opcode)
         OP_ADD, OP_AND, OP_NOT, OP_LDR, OP_LDB, OP_LDI,
         OP_STR, OP_STB, OP_STI, OP_JMP: sr1_read = 1'b1;
         default:                        sr1_read = 1'b0;
      endcase
   end

   // Stores carry their data register (IR[11:9]) on id_sr2.
   assign sr2_read   = (((id_opcode == OP_ADD) | (id_opcode == OP_AND)) & ~id_bit5)
                     | (id_opcode == OP_STR) | (id_opcode == OP_STB) | (id_opcode == OP_STI);
   assign ex_is_load = (ex_opcode == OP_LDR) | (ex_opcode == OP_LDB) | (ex_opcode == OP_LDI);
   assign ld_use     = ex_valid & ex_is_load
                     & ((sr1_read & (ex_dest == id_sr1)) | (sr2_read & (ex_dest == id_sr2)));

   always_comb begin
      loads              = 5'b00000;
      flushes            = 3'b000;
      next_state         = state;
      next_flush_pending = flush_pending;
      case (state)
         RUN, REDIRECT: begin
            if (miss) begin
               next_state         = MEM_WAIT;
               next_flush_pending = mem_br_taken;
            end else if (state == RUN && mem_br_taken) begin
               loads      = LOADS_ALL;
               flushes    = 3'b111;
               next_state = REDIRECT;
            end else if (state == RUN && ld_use) begin
               loads   = LOADS_LDUSE;
               flushes = 3'b010;
            end else begin
               loads      = LOADS_ALL;
               next_state = RUN;
            end
         end
         MEM_WAIT: begin
            if (miss) begin
               next_flush_pending = flush_pending | mem_br_taken;
            end else begin
               loads              = LOADS_ALL;
               next_flush_pending = 1'b0;
               if (flush_pending | mem_br_taken) begin
                  flushes    = 3'b111;
                  next_state = REDIRECT;
               end else begin
                  next_state = RUN;
               end
            end
         end
         default: begin
            next_state         = RUN;
            next_flush_pending = 1'b0;
         end
      endcase
   end

   assign {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = reset_n ? loads : 5'b00000;
   assign {if_id_flush, id_ex_flush, ex_mem_flush}                    = reset_n ? flushes : 3'b000;
   assign ctrl_state = reset_n ? state : RUN;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= RUN;
         flush_pending <= 1'b0;
      end else begin
         state         <= next_state;
         flush_pending <= next_flush_pending;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   localparam logic [STALL_CNT_W-1:0] CNT_MAX = '1;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         miss_stall_cnt  <= '0;
         lduse_stall_cnt <= '0;
         flush_cnt       <= '0;
      end else begin
         if (state == MEM_WAIT && miss && miss_stall_cnt != CNT_MAX)
            miss_stall_cnt <= miss_stall_cnt + 1'b1;
         if (loads == LOADS_LDUSE && lduse_stall_cnt != CNT_MAX)
            lduse_stall_cnt <= lduse_stall_cnt + 1'b1;
         if (flushes[2] && flush_cnt != CNT_MAX)
            flush_cnt <= flush_cnt + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued per step and checked mid-cycle.
module tb_pipe_hazard_ctrl;

   localparam int W = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [3:0] id_opcode, ex_opcode;
   logic       id_bit5, ex_valid, mem_br_taken;
   logic [2:0] id_sr1, id_sr2, ex_dest;
   logic       icache_req, icache_resp, dcache_req, dcache_resp;
   logic       pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
   logic       if_id_flush, id_ex_flush, ex_mem_flush;
   logic [1:0] ctrl_state;
`ifdef HAZARD_PERF_CNT_EN
   logic [W-1:0] miss_stall_cnt, lduse_stall_cnt, flush_cnt;
`endif

   pipe_hazard_ctrl #(.STALL_CNT_W(W)) dut (
      .clk(clk), .reset_n(reset_n),
      .id_opcode(id_opcode), .id_bit5(id_bit5), .id_sr1(id_sr1), .id_sr2(id_sr2),
      .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_dest(ex_dest),
      .mem_br_taken(mem_br_taken),
      .icache_req(icache_req), .icache_resp(icache_resp),
      .dcache_req(dcache_req), .dcache_resp(dcache_resp),
      .pc_load(pc_load), .if_id_load(if_id_load), .id_ex_load(id_ex_load),
      .ex_mem_load(ex_mem_load), .mem_wb_load(mem_wb_load),
      .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush),
      .ctrl_state(ctrl_state)
`ifdef HAZARD_PERF_CNT_EN
      , .miss_stall_cnt(miss_stall_cnt), .lduse_stall_cnt(lduse_stall_cnt), .flush_cnt(flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   localparam logic [4:0] NORM = 5'b11111, STL = 5'b00000, LDL = 5'b00111;
   localparam logic [2:0] F0 = 3'b000, FA = 3'b111, FL = 3'b010;
   localparam logic [1:0] S_RUN = 2'b00, S_MW = 2'b01, S_RD = 2'b10;
   localparam logic [3:0] ADD = 4'b0001, AND = 4'b0101, NOT = 4'b1001, BR = 4'b0000;
   localparam logic [3:0] LDR = 4'b0110, LDB = 4'b0010, LDI = 4'b1010, STR = 4'b0111, JMP = 4'b1100;

   typedef struct {
      logic [9:0] v;
      string      tag;
   } exp_t;

   exp_t q[$];
   int   tests = 0;
   int   fails = 0;
   logic [9:0] obs;

   assign obs = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
                 if_id_flush, id_ex_flush, ex_mem_flush, ctrl_state};

   task automatic set_pipe(input logic exv, input logic [3:0] exop, input logic [2:0] exd,
                           input logic [3:0] iop, input logic b5,
                           input logic [2:0] s1, input logic [2:0] s2);
      ex_valid = exv; ex_opcode = exop; ex_dest = exd;
      id_opcode = iop; id_bit5 = b5; id_sr1 = s1; id_sr2 = s2;
   endtask

   task automatic set_mem(input logic ireq, input logic iresp, input logic dreq,
                          input logic dresp, input logic br);
      icache_req = ireq; icache_resp = iresp;
      dcache_req = dreq; dcache_resp = dresp; mem_br_taken = br;
   endtask

   // Queue the expectation for the cycle just driven, then check it at mid-cycle.
   task automatic cyc(input logic [4:0] ld, input logic [2:0] fl, input logic [1:0] st,
                      input string tag);
      exp_t x;
      x.v = {ld, fl, st};
      x.tag = tag;
      q.push_back(x);
      @(negedge clk);
      x = q.pop_front();
      tests++;
      assert (obs === x.v) else begin
         fails++;
         $error("FAIL %s: observed %b required %b", x.tag, obs, x.v);
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      set_pipe(1'b0, BR, 3'd0, BR, 1'b0, 3'd0, 3'd0);
      set_mem(1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(STL, F0, S_RUN, "reset_outputs_0");
      cyc(STL, F0, S_RUN, "reset_outputs_1");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset_n = 1'b1;
      cyc(NORM, F0, S_RUN, "idle_run");

      // Load-use decode cases
      set_pipe(1'b1, LDR, 3'd3, ADD, 1'b0, 3'd1, 3'd3);
      cyc(LDL, FL, S_RUN, "lduse_add_sr2");
      set_pipe(1'b1, ADD, 3'd1, ADD, 1'b0, 3'd1, 3'd3);
      cyc(NORM, F0, S_RUN, "lduse_after_bubble");
      set_pipe(1'b1, LDR, 3'd3, ADD, 1'b1, 3'd2, 3'd3);
      cyc(NORM, F0, S_RUN, "imm_false_positive");
      set_pipe(1'b1, LDB, 3'd5, JMP, 1'b0, 3'd5, 3'd0);
      cyc(LDL, FL, S_RUN, "lduse_ldb_jmp_sr1");
      set_pipe(1'b1, LDI, 3'd4, STR, 1'b0, 3'd0, 3'd4);
      cyc(LDL, FL, S_RUN, "lduse_ldi_str_sr2");
      set_pipe(1'b1, LDR, 3'd2, AND, 1'b0, 3'd6, 3'd2);
      cyc(LDL, FL, S_RUN, "lduse_and_sr2");
      set_pipe(1'b1, LDR, 3'd2, NOT, 1'b0, 3'd6, 3'd2);
      cyc(NORM, F0, S_RUN, "not_ignores_sr2");
      set_pipe(1'b0, LDR, 3'd3, ADD, 1'b0, 3'd3, 3'd3);
      cyc(NORM, F0, S_RUN, "ex_bubble_no_stall");
      set_pipe(1'b1, ADD, 3'd3, ADD, 1'b0, 3'd3, 3'd3);
      cyc(NORM, F0, S_RUN, "ex_not_load");
      set_pipe(1'b1, LDR, 3'd3, BR, 1'b0, 3'd3, 3'd3);
      cyc(NORM, F0, S_RUN, "br_reads_no_reg");
      set_pipe(1'b0, BR, 3'd0, BR, 1'b0, 3'd0, 3'd0);

      // 4-cycle dcache miss
      set_mem(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(STL, F0, S_RUN, "dmiss_c1");
      cyc(STL, F0, S_MW,  "dmiss_c2");
      cyc(STL, F0, S_MW,  "dmiss_c3");
      set_mem(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(NORM, F0, S_MW, "dmiss_resp");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_RUN, "dmiss_back_run");

      // Branch during icache miss
      set_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(STL, F0, S_RUN, "imiss_c1");
      set_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(STL, F0, S_MW, "imiss_br_c2");
      set_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(STL, F0, S_MW, "imiss_c3");
      cyc(STL, F0, S_MW, "imiss_c4");
      set_mem(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(NORM, FA, S_MW, "imiss_resp_flush");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_RD, "imiss_redirect");
      cyc(NORM, F0, S_RUN, "imiss_back_run");

      // Branch in RUN, ld_use suppressed in REDIRECT
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(NORM, FA, S_RUN, "br_flush");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      set_pipe(1'b1, LDR, 3'd3, ADD, 1'b0, 3'd3, 3'd0);
      cyc(NORM, F0, S_RD, "redirect_suppress_lduse");
      cyc(LDL, FL, S_RUN, "lduse_after_redirect");

      // Miss + branch + ld_use together in RUN
      set_mem(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(STL, F0, S_RUN, "triple_miss_wins");
      set_mem(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(STL, F0, S_MW, "triple_wait");
      set_mem(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(NORM, FA, S_MW, "triple_pending_flush");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_RD, "triple_redirect");
      set_pipe(1'b0, BR, 3'd0, BR, 1'b0, 3'd0, 3'd0);
      cyc(NORM, F0, S_RUN, "triple_back_run");

      // Both caches missing, responses on different cycles, then miss in REDIRECT
      set_mem(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(STL, F0, S_RUN, "dual_c1");
      set_mem(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(STL, F0, S_MW, "dual_iresp_only");
      set_mem(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      cyc(NORM, F0, S_MW, "dual_dresp");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      cyc(NORM, FA, S_RUN, "br_before_rd_miss");
      set_mem(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(STL, F0, S_RD, "miss_in_redirect");
      set_mem(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_MW, "rd_miss_resp_noflush");
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_RUN, "rd_miss_back_run");

      // Reset during MEM_WAIT with a pending flush
      set_mem(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      cyc(STL, F0, S_RUN, "rst_mw_c1");
      set_mem(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      cyc(STL, F0, S_MW, "rst_mw_c2");
      reset_n = 1'b0;
      cyc(STL, F0, S_RUN, "rst_mw_in_reset");
      reset_n = 1'b1;
      set_mem(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(NORM, F0, S_RUN, "rst_mw_no_flush");
`ifdef HAZARD_PERF_CNT_EN
      tests++;
      assert ({miss_stall_cnt, lduse_stall_cnt, flush_cnt} === '0) else begin
         fails++;
         $error("FAIL perf_cnt_reset: observed %0d/%0d/%0d required 0/0/0",
                miss_stall_cnt, lduse_stall_cnt, flush_cnt);
      end
`endif
      cyc(NORM, F0, S_RUN, "rst_mw_steady");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
